// File: rtl/elevator_call_dispatcher.sv
// Elevator call dispatcher: latches hall/car calls and picks the next target floor with a SCAN schedule.
// Optional STUCK_WDT_EN macro adds a stuck-car watchdog that raises a sticky fault.
module elevator_call_dispatcher #(
   parameter int NUM_FLOORS    = 15,
   parameter int DOOR_HOLD_CYC = 8,
   parameter int WDT_CYC       = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [4:0]            car_floor,
   input  logic [1:0]            car_door,
   input  logic [1:0]            car_up,
   input  logic [1:0]            car_down,
   output logic [4:0]            requested_floor,
   output logic                  req_valid,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  served,
   output logic [4:0]            served_floor,
   output logic                  dir_up,
   output logic                  fault
);

   // state        | meaning
   // S_IDLE       | no dispatch; requested_floor = 31
   // S_SWEEP_UP   | heading up to lowest pending floor at/above the car
   // S_SWEEP_DOWN | heading down to highest pending floor at/below the car
   // S_DOOR_HOLD  | call retired; door held for DOOR_HOLD_CYC cycles
   typedef enum logic [1:0] {S_IDLE, S_SWEEP_UP, S_SWEEP_DOWN, S_DOOR_HOLD} state_t;

   localparam logic [4:0]    IDLE_CODE = 5'd31;
   localparam logic [4:0]    TOP_FLOOR = 5'(NUM_FLOORS - 1);
   localparam int            HW        = $clog2(DOOR_HOLD_CYC + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(DOOR_HOLD_CYC);

   state_t                r_state, w_nx_state;
   logic [4:0]            r_req, w_nx_req;
   logic                  r_req_valid, w_nx_valid;
   logic [NUM_FLOORS-1:0] r_pending, w_nx_pending;
   logic                  r_served, w_nx_served;
   logic [4:0]            r_served_floor, w_nx_served_floor;
   logic                  r_dir_up, w_nx_dir;
   logic [HW-1:0]         r_hold_cnt, w_nx_hold;
   logic [NUM_FLOORS-1:0] r_btn_q;

   logic [NUM_FLOORS-1:0] w_rise;
   logic [4:0]            w_floor_c;
   logic                  w_arrive;
   logic                  w_wdt_fire;
   logic                  w_fault_q;
   logic                  w_do_arrive, w_do_sweep;
   logic [4:0]            w_arr_floor, w_near;
   logic [5:0]            w_pick;
   logic                  w_unused;

   function automatic logic [NUM_FLOORS-1:0] fl_mask(input logic [4:0] f);
      return NUM_FLOORS'(1) << f;
   endfunction

   // Returns {direction, target}; reverses when nothing is left ahead of the car.
   function automatic logic [5:0] sweep_pick(input logic up, input logic [NUM_FLOORS-1:0] pend,
                                             input logic [4:0] f);
      logic [4:0] ahead, behind;
      logic       found;
      ahead  = '0;
      behind = '0;
      found  = 1'b0;
      if (up) begin
         for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pend[i] && 5'(i) >= f) begin ahead = 5'(i); found = 1'b1; end
         for (int i = 0; i < NUM_FLOORS; i++)
            if (pend[i] && 5'(i) < f) behind = 5'(i);
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++)
            if (pend[i] && 5'(i) <= f) begin ahead = 5'(i); found = 1'b1; end
         for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pend[i] && 5'(i) > f) behind = 5'(i);
      end
      return found ? {up, ahead} : {~up, behind};
   endfunction

   // Ascending scan with strict compare keeps the lower floor on a distance tie.
   function automatic logic [4:0] nearest(input logic [NUM_FLOORS-1:0] pend, input logic [4:0] f);
      logic [4:0] best, best_d, d;
      best   = '0;
      best_d = 5'd31;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         d = (5'(i) > f) ? 5'(i) - f : f - 5'(i);
         if (pend[i] && d < best_d) begin best_d = d; best = 5'(i); end
      end
      return best;
   endfunction

   assign w_rise    = call_btn & ~r_btn_q;
   assign w_floor_c = (car_floor > TOP_FLOOR) ? TOP_FLOOR : car_floor;
   assign w_arrive  = r_req_valid && car_door[0] && (car_floor == r_req);
   assign w_unused  = ^{car_up, car_down, car_door[1]};

`ifdef STUCK_WDT_EN
   localparam int WW = $clog2(WDT_CYC + 1);
   logic [WW-1:0] r_wdt_cnt;
   logic [4:0]    r_car_q;
   logic          r_fault;
   logic          w_sweeping;

   assign w_sweeping = (r_state == S_SWEEP_UP) || (r_state == S_SWEEP_DOWN);
   assign w_wdt_fire = w_sweeping && !w_arrive && (car_floor == r_car_q) && (r_wdt_cnt == WW'(1));
   assign w_fault_q  = r_fault;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wdt_cnt <= WW'(WDT_CYC);
         r_car_q   <= '0;
         r_fault   <= 1'b0;
      end else begin
         r_car_q <= car_floor;
         if (w_wdt_fire) r_fault <= 1'b1;
         if (!w_sweeping || w_arrive || (car_floor != r_car_q) || w_wdt_fire)
            r_wdt_cnt <= WW'(WDT_CYC);
         else
            r_wdt_cnt <= r_wdt_cnt - WW'(1);
      end
   end
`else
   logic w_unused_wdt;
   assign w_unused_wdt = (WDT_CYC > 0);
   assign w_wdt_fire   = 1'b0;
   assign w_fault_q    = 1'b0;
`endif

   always_comb begin
      w_nx_state        = r_state;
      w_nx_req          = r_req;
      w_nx_valid        = r_req_valid;
      w_nx_pending      = r_pending | w_rise;
      w_nx_served       = 1'b0;
      w_nx_served_floor = r_served_floor;
      w_nx_dir          = r_dir_up;
      w_nx_hold         = r_hold_cnt;
      w_do_arrive       = 1'b0;
      w_do_sweep        = 1'b0;
      w_arr_floor       = r_req;
      w_near            = nearest(r_pending, w_floor_c);
      w_pick            = '0;
      case (r_state)
         S_IDLE: begin
            w_nx_req   = IDLE_CODE;
            w_nx_valid = 1'b0;
            if (r_pending != '0 && !w_fault_q) begin
               if (w_near == car_floor) begin
                  w_do_arrive = 1'b1;
                  w_arr_floor = w_near;
               end else begin
                  w_nx_req   = w_near;
                  w_nx_valid = 1'b1;
                  w_nx_dir   = (w_near > w_floor_c);
                  w_nx_state = (w_near > w_floor_c) ? S_SWEEP_UP : S_SWEEP_DOWN;
               end
            end
         end
         S_SWEEP_UP, S_SWEEP_DOWN: begin
            if (w_arrive) begin
               w_do_arrive = 1'b1;
            end else if (r_pending == '0) begin
               w_nx_state = S_IDLE;
               w_nx_req   = IDLE_CODE;
               w_nx_valid = 1'b0;
            end else begin
               w_do_sweep = 1'b1;
            end
         end
         S_DOOR_HOLD: begin
            // A re-press of the held floor extends the hold instead of queuing a new call.
            w_nx_pending = r_pending | (w_rise & ~fl_mask(r_req));
            if ((w_rise & fl_mask(r_req)) != '0) begin
               w_nx_hold = HOLD_LOAD;
            end else if (r_hold_cnt <= HW'(1)) begin
               w_nx_hold = '0;
               if (r_pending != '0) begin
                  w_do_sweep = 1'b1;
               end else begin
                  w_nx_state = S_IDLE;
                  w_nx_req   = IDLE_CODE;
                  w_nx_valid = 1'b0;
               end
            end else begin
               w_nx_hold = r_hold_cnt - HW'(1);
            end
         end
         default: w_nx_state = S_IDLE;
      endcase

      if (w_do_sweep) begin
         w_pick     = sweep_pick(r_dir_up, r_pending, w_floor_c);
         w_nx_dir   = w_pick[5];
         w_nx_req   = w_pick[4:0];
         w_nx_valid = 1'b1;
         w_nx_state = w_pick[5] ? S_SWEEP_UP : S_SWEEP_DOWN;
      end
      if (w_do_arrive) begin
         w_nx_pending      = w_nx_pending & ~fl_mask(w_arr_floor);
         w_nx_served       = 1'b1;
         w_nx_served_floor = w_arr_floor;
         w_nx_hold         = HOLD_LOAD;
         w_nx_req          = w_arr_floor;
         w_nx_valid        = 1'b1;
         w_nx_state        = S_DOOR_HOLD;
      end
      if (w_wdt_fire) begin
         w_nx_pending = w_nx_pending & ~fl_mask(r_req);
         w_nx_req     = IDLE_CODE;
         w_nx_valid   = 1'b0;
         w_nx_state   = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_req          <= IDLE_CODE;
         r_req_valid    <= 1'b0;
         r_pending      <= '0;
         r_served       <= 1'b0;
         r_served_floor <= '0;
         r_dir_up       <= 1'b1;
         r_hold_cnt     <= '0;
         r_btn_q        <= '0;
      end else begin
         r_state        <= w_nx_state;
         r_req          <= w_nx_req;
         r_req_valid    <= w_nx_valid;
         r_pending      <= w_nx_pending;
         r_served       <= w_nx_served;
         r_served_floor <= w_nx_served_floor;
         r_dir_up       <= w_nx_dir;
         r_hold_cnt     <= w_nx_hold;
         r_btn_q        <= call_btn;
      end
   end

   assign requested_floor = r_req;
   assign req_valid       = r_req_valid;
   assign pending         = r_pending;
   assign served          = r_served;
   assign served_floor    = r_served_floor;
   assign dir_up          = r_dir_up;
   assign fault           = w_fault_q;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Bench for elevator_call_dispatcher: scripted calls, a simple car model and a served-floor scoreboard.
module tb_elevator_call_dispatcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] call_btn = '0;
   logic [4:0]  car_floor = '0;
   logic [1:0]  car_door = '0;
   logic [1:0]  car_up = '0;
   logic [1:0]  car_down = '0;
   logic [4:0]  requested_floor;
   logic        req_valid;
   logic [14:0] pending;
   logic        served;
   logic [4:0]  served_floor;
   logic        dir_up;
   logic        fault;

   int n_checks = 0;
   int n_errors = 0;
   int served_cnt = 0;
   int mv_cnt = 0;
   logic prev_served = 1'b0;
   int sb_q[$];

   elevator_call_dispatcher dut (
      .clk(clk), .reset(reset), .call_btn(call_btn), .car_floor(car_floor),
      .car_door(car_door), .car_up(car_up), .car_down(car_down),
      .requested_floor(requested_floor), .req_valid(req_valid), .pending(pending),
      .served(served), .served_floor(served_floor), .dir_up(dir_up), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Car moves one floor every 3 cycles toward the target and opens the door on reaching it.
   task automatic car_step();
      if (req_valid && requested_floor < 5'd15) begin
         if (car_floor == requested_floor) begin
            car_door = 2'b01;
         end else begin
            car_door = 2'b00;
            mv_cnt++;
            if (mv_cnt == 3) begin
               mv_cnt = 0;
               car_floor = (requested_floor > car_floor) ? car_floor + 5'd1 : car_floor - 5'd1;
            end
         end
      end else begin
         car_door = 2'b00;
      end
   endtask

   task automatic run_until_served(input int n, input int budget);
      int c = 0;
      while (served_cnt < n && c < budget) begin
         tick();
         car_step();
         c++;
      end
      check_eq("serve_wait", 32'(served_cnt), 32'(n));
   endtask

   task automatic run_until_idle(input int budget);
      int c = 0;
      while (req_valid && c < budget) begin
         tick();
         car_step();
         c++;
      end
      check_eq("idle_wait", 32'(req_valid), 0);
   endtask

   task automatic press(input logic [14:0] mask);
      call_btn = mask;
      tick();
      call_btn = '0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (served) begin
            check_eq("served_one_cycle", 32'(prev_served), 0);
            if (sb_q.size() == 0) begin
               check_eq("served_unexpected", 32'(served_floor), 32'd99);
            end else begin
               check_eq("served_floor", 32'(served_floor), 32'(sb_q.pop_front()));
            end
            served_cnt++;
         end
         prev_served = served;
      end
   end

   initial begin
      int base;
      #1 reset = 1'b0;
      #2;
      check_eq("rst_req", 32'(requested_floor), 31);
      check_eq("rst_valid", 32'(req_valid), 0);
      check_eq("rst_pending", 32'(pending), 0);
      check_eq("rst_served", 32'(served), 0);
      check_eq("rst_served_floor", 32'(served_floor), 0);
      check_eq("rst_dir", 32'(dir_up), 1);
      check_eq("rst_fault", 32'(fault), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < 20; k++) begin
         tick();
         check_eq("idle_req", 32'(requested_floor), 31);
         check_eq("idle_valid", 32'(req_valid), 0);
         check_eq("idle_pending", 32'(pending), 0);
      end

      // Single call to floor 5 with manual car.
      car_floor = 5'd0;
      press(15'd1 << 5);
      check_eq("p5_pending", 32'(pending), 32'h20);
      check_eq("p5_req_not_yet", 32'(requested_floor), 31);
      tick();
      check_eq("p5_req", 32'(requested_floor), 5);
      check_eq("p5_valid", 32'(req_valid), 1);
      check_eq("p5_dir", 32'(dir_up), 1);
      sb_q.push_back(5);
      car_floor = 5'd5;
      car_door  = 2'b01;
      tick();
      check_eq("p5_served", 32'(served), 1);
      check_eq("p5_cleared", 32'(pending), 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) check_eq("p5_served_drop", 32'(served), 0);
         check_eq("p5_hold_req", 32'(requested_floor), (k < 8) ? 32'd5 : 32'd31);
      end
      car_door = 2'b00;

      // Sweep up to 9 from 3, picking up 6 in flight, then reversing to 1.
      car_floor = 5'd3;
      press(15'd1 << 9);
      tick();
      check_eq("sw_req9", 32'(requested_floor), 9);
      check_eq("sw_dir_up", 32'(dir_up), 1);
      press((15'd1 << 6) | (15'd1 << 1));
      tick();
      check_eq("sw_req6", 32'(requested_floor), 6);
      sb_q.push_back(6);
      sb_q.push_back(9);
      sb_q.push_back(1);
      mv_cnt = 0;
      run_until_served(4, 800);
      check_eq("sw_dir_down", 32'(dir_up), 0);
      run_until_idle(100);
      check_eq("sw_pending_empty", 32'(pending), 0);

      // Equal-distance tie from floor 4 goes to the lower floor first.
      car_floor = 5'd4;
      car_door  = 2'b00;
      press((15'd1 << 2) | (15'd1 << 6));
      tick();
      check_eq("tie_req", 32'(requested_floor), 2);
      check_eq("tie_dir", 32'(dir_up), 0);
      sb_q.push_back(2);
      sb_q.push_back(6);
      mv_cnt = 0;
      run_until_served(6, 800);
      run_until_idle(100);
      check_eq("tie_dir_after", 32'(dir_up), 1);

      // Door hold at 7: re-press restarts the hold; other floors latch; reset mid-hold.
      car_floor = 5'd6;
      car_door  = 2'b00;
      press(15'd1 << 7);
      tick();
      check_eq("dh_req", 32'(requested_floor), 7);
      car_floor = 5'd7;
      car_door  = 2'b01;
      sb_q.push_back(7);
      tick();
      check_eq("dh_served", 32'(served), 1);
      repeat (3) tick();
      press(15'd1 << 7);
      check_eq("dh_press_no_latch", 32'(pending), 0);
      for (int k = 1; k <= 7; k++) begin
         if (k == 1) call_btn = 15'd1 << 12;
         tick();
         if (k == 1) begin
            call_btn = '0;
            check_eq("dh_other_latched", 32'(pending), 32'h1000);
         end
         check_eq("dh_hold_extended", 32'(requested_floor), 7);
      end
      #3 reset = 1'b0;
      #1;
      check_eq("mid_rst_req", 32'(requested_floor), 31);
      check_eq("mid_rst_pending", 32'(pending), 0);
      check_eq("mid_rst_valid", 32'(req_valid), 0);
      car_door = 2'b00;
      @(negedge clk);
      reset = 1'b1;

      // Car frozen at floor 2 with target 10.
      car_floor = 5'd2;
      tick();
      press(15'd1 << 10);
      tick();
      check_eq("wdt_req", 32'(requested_floor), 10);
`ifdef STUCK_WDT_EN
      repeat (63) tick();
      check_eq("wdt_not_yet", 32'(fault), 0);
      check_eq("wdt_req_held", 32'(requested_floor), 10);
      tick();
      check_eq("wdt_fault", 32'(fault), 1);
      check_eq("wdt_dropped", 32'(pending), 0);
      check_eq("wdt_req_idle", 32'(requested_floor), 31);
      press(15'd1 << 3);
      repeat (2) tick();
      check_eq("wdt_call_latched", 32'(pending), 32'h8);
      check_eq("wdt_req_blocked", 32'(requested_floor), 31);
      check_eq("wdt_sticky", 32'(fault), 1);
`else
      repeat (70) tick();
      check_eq("nowdt_fault", 32'(fault), 0);
      check_eq("nowdt_req", 32'(requested_floor), 10);
      check_eq("nowdt_pending", 32'(pending), 32'h400);
`endif
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Out-of-range car floor: clamped for direction, never an arrival.
      car_floor = 5'd20;
      car_door  = 2'b01;
      base = served_cnt;
      tick();
      press(15'd1 << 3);
      tick();
      check_eq("oor_req", 32'(requested_floor), 3);
      check_eq("oor_dir", 32'(dir_up), 0);
      repeat (10) tick();
      check_eq("oor_no_arrival", 32'(served_cnt), 32'(base));
      check_eq("oor_pending", 32'(pending), 32'h8);

      check_eq("sb_empty", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
